cdb_wb_arbiter: RTL and testbench
=================================

CDB_WB_ARBITER -- requirements
Module: cdb_wb_arbiter

Interface
REQ-001 Parameter TAG_W, default 4: rename tag width; tag value 0 is the reserved "free" tag.
REQ-002 Parameter REG_W, default 5: architectural register name width.
REQ-003 Parameter DATA_W, default 32: result data width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 flush  input  1  pipeline flush (mispredict); synchronous.
REQ-007 req_valid  input  3  per-requester result valid; bit0 ALU, bit1 LSU, bit2 BRU.
REQ-008 req_ready  output  3  per-requester grant/accept, one-hot or zero.
REQ-009 req_tag  input  3*TAG_W  packed tags, requester i in slice [i*TAG_W +: TAG_W].
REQ-010 req_rd  input  3*REG_W  packed destination register names, same packing.
REQ-011 req_data  input  3*DATA_W  packed result data, same packing.
REQ-012 cdb_valid  output  1  broadcast valid for one cycle.
REQ-013 cdb_tag / cdb_rd / cdb_data  output  TAG_W / REG_W / DATA_W  broadcast payload.
REQ-014 rf_we  output  1  register-file write enable.
REQ-015 cdb_src  output  2  index (0..2) of requester owning the current broadcast.
REQ-016 err_tag0  output  1  sticky flag: a tag-0 request was accepted.

Function
REQ-017 At most one requester SHALL be granted per cycle; req_ready[i]=1 only when req_valid[i]=1 and i wins arbitration; req_ready is combinational from req_valid, ptr and flush.
REQ-018 A transfer occurs when req_valid[i] && req_ready[i]; requesters hold valid and payload stable until transferred.
REQ-019 Round-robin: 2-bit pointer ptr in {0,1,2}; search order ptr, ptr+1, ptr+2 (mod 3); first valid wins.
REQ-020 After a grant to i, ptr SHALL become (i+1) mod 3; with no grant ptr holds.
REQ-021 A transfer in cycle N SHALL appear on cdb_* in cycle N+1 for exactly one cycle (registered outputs, latency 1); no back-pressure from the CDB.
REQ-022 cdb_valid SHALL be 0 in any cycle following a cycle with no transfer; cdb_tag/rd/data/src hold their last value when cdb_valid=0.
REQ-023 rf_we = cdb_valid && (cdb_rd != 0); x0 results broadcast on the CDB but never write the register file.
REQ-024 A transfer with tag 0 SHALL be accepted (ready asserted), SHALL NOT produce cdb_valid, and SHALL set err_tag0, which stays 1 until reset.
REQ-025 When flush=1: req_ready=0, no transfer, next-cycle cdb_valid=0, ptr returns to 0; a broadcast already on cdb_* in the flush cycle completes unchanged.
REQ-026 All three valid every cycle: grants rotate 0,1,2,0,... starting at ptr; each requester waits at most 2 cycles.

Reset
REQ-027 rst asserted SHALL immediately force cdb_valid=0, rf_we=0, err_tag0=0, ptr=0, cdb_src=0, cdb_tag=0, cdb_rd=0, cdb_data=0.
REQ-028 While rst=1, req_ready SHALL be 0; reset mid-broadcast drops that broadcast.
REQ-029 First arbitration after reset release SHALL search from requester 0.

Configuration
REQ-030 Macro CDB_ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority ALU(0) > LSU(1) > BRU(2), ptr not implemented, flush has no ptr effect; when undefined, round-robin per REQ-019/020.

Verification
REQ-031 Reset, then req_valid=001, tag=3, rd=5, data=0xDEADBEEF -> cycle 1 req_ready=001; cycle 2 cdb_valid=1, cdb_tag=3, cdb_rd=5, cdb_data=0xDEADBEEF, rf_we=1, cdb_src=0.
REQ-032 req_valid=111 held 6 cycles (RR build) -> req_ready sequence 001,010,100,001,010,100; cdb_src 0,1,2,0,1,2 one cycle later.
REQ-033 Single LSU request rd=0, tag=7 -> next cycle cdb_valid=1, rf_we=0.
REQ-034 ALU request tag=0 -> req_ready=001, next cycle cdb_valid=0, err_tag0=1 and stays 1 until rst.
REQ-035 After grant to 0 (ptr=1), flush=1 with req_valid=111 -> req_ready=000, next cycle cdb_valid=0; following cycle grant 001.
REQ-036 CDB_ARB_FIXED_PRIO_EN defined, req_valid=111 for 3 cycles -> req_ready=001 each cycle; LSU/BRU never granted.

Source files
------------

// File: rtl/cdb_wb_arbiter.sv
// cdb_wb_arbiter: three-way round-robin arbiter (ALU, LSU, BRU) feeding a single
// common data bus and register-file write port with a one-cycle registered broadcast.
// Optional build macro CDB_ARB_FIXED_PRIO_EN selects fixed priority ALU > LSU > BRU
// in place of round-robin; the default build (macro undefined) is round-robin.
module cdb_wb_arbiter #(
  parameter int TAG_W  = 4,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [2:0]          req_valid,
  output logic [2:0]          req_ready,
  input  logic [3*TAG_W-1:0]  req_tag,
  input  logic [3*REG_W-1:0]  req_rd,
  input  logic [3*DATA_W-1:0] req_data,
  output logic                cdb_valid,
  output logic [TAG_W-1:0]    cdb_tag,
  output logic [REG_W-1:0]    cdb_rd,
  output logic [DATA_W-1:0]   cdb_data,
  output logic                rf_we,
  output logic [1:0]          cdb_src,
  output logic                err_tag0
);

  logic [1:0]        start_s;
  logic              hit_s;
  logic [1:0]        win_s;
  logic [2:0]        grant_s;
  logic [TAG_W-1:0]  sel_tag_s;
  logic [REG_W-1:0]  sel_rd_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              tag_nz_s;

  // Search three requesters starting at 'start'; returns {hit, index}.
  function automatic logic [2:0] pick_first(input logic [2:0] v, input logic [1:0] start);
    logic [1:0] c;
    logic       found;
    logic [1:0] idx;
    c     = start;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (!found && v[c]) begin
        found = 1'b1;
        idx   = c;
      end
      c = (c == 2'd2) ? 2'd0 : c + 2'd1;
    end
    return {found, idx};
  endfunction

`ifdef CDB_ARB_FIXED_PRIO_EN
  // Fixed priority: the search always begins at the ALU.
  assign start_s = 2'd0;
`else
  logic [1:0] ptr_r;

  // Round-robin pointer: one past the last winner, back to 0 on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= 2'd0;
    end else if (flush) begin
      ptr_r <= 2'd0;
    end else if (hit_s) begin
      case (win_s)
        2'd0:    ptr_r <= 2'd1;
        2'd1:    ptr_r <= 2'd2;
        2'd2:    ptr_r <= 2'd0;
        default: ptr_r <= 2'd0;
      endcase
    end
  end

  assign start_s = ptr_r;
`endif

  // Grant selection: nothing is accepted during reset or flush.
  always_comb begin
    hit_s   = 1'b0;
    win_s   = 2'd0;
    grant_s = 3'b000;
    if (rst || flush) begin
      hit_s   = 1'b0;
      win_s   = 2'd0;
      grant_s = 3'b000;
    end else begin
      {hit_s, win_s} = pick_first(req_valid, start_s);
      if (hit_s) begin
        grant_s = 3'b001 << win_s;
      end else begin
        grant_s = 3'b000;
      end
    end
  end

  assign req_ready = grant_s;

  // Payload mux for the winning requester.
  always_comb begin
    sel_tag_s  = {TAG_W{1'b0}};
    sel_rd_s   = {REG_W{1'b0}};
    sel_data_s = {DATA_W{1'b0}};
    case (win_s)
      2'd0: begin
        sel_tag_s  = req_tag[0 +: TAG_W];
        sel_rd_s   = req_rd[0 +: REG_W];
        sel_data_s = req_data[0 +: DATA_W];
      end
      2'd1: begin
        sel_tag_s  = req_tag[TAG_W +: TAG_W];
        sel_rd_s   = req_rd[REG_W +: REG_W];
        sel_data_s = req_data[DATA_W +: DATA_W];
      end
      2'd2: begin
        sel_tag_s  = req_tag[2*TAG_W +: TAG_W];
        sel_rd_s   = req_rd[2*REG_W +: REG_W];
        sel_data_s = req_data[2*DATA_W +: DATA_W];
      end
      default: begin
        sel_tag_s  = {TAG_W{1'b0}};
        sel_rd_s   = {REG_W{1'b0}};
        sel_data_s = {DATA_W{1'b0}};
      end
    endcase
  end

  assign tag_nz_s = (sel_tag_s != {TAG_W{1'b0}});

  // Broadcast register: a tagged transfer shows up for exactly one cycle; payload
  // holds between broadcasts; tag-0 transfers are swallowed and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      rf_we     <= 1'b0;
      cdb_tag   <= {TAG_W{1'b0}};
      cdb_rd    <= {REG_W{1'b0}};
      cdb_data  <= {DATA_W{1'b0}};
      cdb_src   <= 2'd0;
      err_tag0  <= 1'b0;
    end else begin
      cdb_valid <= hit_s && tag_nz_s;
      rf_we     <= hit_s && tag_nz_s && (sel_rd_s != {REG_W{1'b0}});
      if (hit_s && tag_nz_s) begin
        cdb_tag  <= sel_tag_s;
        cdb_rd   <= sel_rd_s;
        cdb_data <= sel_data_s;
        cdb_src  <= win_s;
      end
      if (hit_s && !tag_nz_s) begin
        err_tag0 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Self-checking bench for cdb_wb_arbiter: directed steps followed by randomized
// traffic, all compared against a behavioural model of the arbitration rules.
module tb_cdb_wb_arbiter;
  localparam int TAG_W  = 4;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                flush = 1'b0;
  logic [2:0]          req_valid = 3'b000;
  logic [2:0]          req_ready;
  logic [3*TAG_W-1:0]  req_tag = '0;
  logic [3*REG_W-1:0]  req_rd = '0;
  logic [3*DATA_W-1:0] req_data = '0;
  logic                cdb_valid;
  logic [TAG_W-1:0]    cdb_tag;
  logic [REG_W-1:0]    cdb_rd;
  logic [DATA_W-1:0]   cdb_data;
  logic                rf_we;
  logic [1:0]          cdb_src;
  logic                err_tag0;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_ptr;
  logic        m_valid;
  logic [31:0] m_tag, m_rd, m_data;
  int          m_src;
  logic        m_err;

  always #5 clk = ~clk;

  cdb_wb_arbiter #(.TAG_W(TAG_W), .REG_W(REG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_rd(req_rd), .req_data(req_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_rd(cdb_rd), .cdb_data(cdb_data),
    .rf_we(rf_we), .cdb_src(cdb_src), .err_tag0(err_tag0)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_tag = 0; m_rd = 0; m_data = 0; m_src = 0; m_err = 1'b0;
  endtask

  // Winner by the arbitration rule: first valid requester from the search start.
  function automatic int model_pick();
    int start;
`ifdef CDB_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    if (rst || flush) return -1;
    for (int k = 0; k < 3; k++) begin
      if (req_valid[(start + k) % 3]) return (start + k) % 3;
    end
    return -1;
  endfunction

  // One clock: check combinational ready and current CDB state, then advance model.
  task automatic cycle(output int g);
    logic [2:0] exp_ready;
    int t, r, d;
    g = model_pick();
    exp_ready = (g < 0) ? 3'b000 : 3'(1 << g);
    #3;
    chk("req_ready", {61'd0, req_ready}, {61'd0, exp_ready});
    chk("cdb_valid", {63'd0, cdb_valid}, {63'd0, m_valid});
    chk("rf_we", {63'd0, rf_we}, {63'd0, (m_valid && m_rd != 0)});
    chk("err_tag0", {63'd0, err_tag0}, {63'd0, m_err});
    chk("cdb_src", {62'd0, cdb_src}, 64'(m_src));
    chk("cdb_tag", {60'd0, cdb_tag}, {32'd0, m_tag});
    chk("cdb_rd", {59'd0, cdb_rd}, {32'd0, m_rd});
    chk("cdb_data", {32'd0, cdb_data}, {32'd0, m_data});
    @(posedge clk);
    m_valid = 1'b0;
    if (g >= 0) begin
      t = int'(req_tag[g*TAG_W +: TAG_W]);
      r = int'(req_rd[g*REG_W +: REG_W]);
      d = int'(req_data[g*DATA_W +: DATA_W]);
      if (t != 0) begin
        m_valid = 1'b1; m_tag = 32'(t); m_rd = 32'(r); m_data = 32'(d); m_src = g;
      end else begin
        m_err = 1'b1;
      end
      m_ptr = (g + 1) % 3;
    end
    if (flush) m_ptr = 0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ready", {61'd0, req_ready}, 64'd0);
    chk("rst_cdb_valid", {63'd0, cdb_valid}, 64'd0);
    chk("rst_err", {63'd0, err_tag0}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_req(input int i, input int t, input int r, input logic [31:0] d);
    req_tag[i*TAG_W +: TAG_W]    = TAG_W'(t);
    req_rd[i*REG_W +: REG_W]     = REG_W'(r);
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    int g;
    logic [2:0] pend;
    model_reset();

    // Reset state with all requesters valid
    req_valid = 3'b111;
    #2;
    chk("reset_ready", {61'd0, req_ready}, 64'd0);
    chk("reset_tag", {60'd0, cdb_tag}, 64'd0);
    chk("reset_data", {32'd0, cdb_data}, 64'd0);
    chk("reset_src", {62'd0, cdb_src}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 3'b000;

    // Single ALU broadcast
    set_req(0, 3, 5, 32'hDEADBEEF);
    req_valid = 3'b001;
    cycle(g);
    req_valid = 3'b000;
    chk("alu_cdb_valid", {63'd0, cdb_valid}, 64'd1);
    chk("alu_cdb_data", {32'd0, cdb_data}, 64'hDEADBEEF);
    chk("alu_rf_we", {63'd0, rf_we}, 64'd1);
    cycle(g);

    // Round-robin rotation with all three valid
    do_reset();
    set_req(0, 1, 1, 32'h11); set_req(1, 2, 2, 32'h22); set_req(2, 3, 3, 32'h33);
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      cycle(g);
      chk("rr_src", {62'd0, cdb_src}, 64'(k % 3));
    end
    req_valid = 3'b000;
    cycle(g);

    // LSU writing x0: broadcast without register write
    set_req(1, 7, 0, 32'h1234);
    req_valid = 3'b010;
    cycle(g);
    req_valid = 3'b000;
    chk("x0_cdb_valid", {63'd0, cdb_valid}, 64'd1);
    chk("x0_rf_we", {63'd0, rf_we}, 64'd0);
    cycle(g);

    // Tag-0 request: accepted, swallowed, sticky error
    set_req(0, 0, 4, 32'h55);
    req_valid = 3'b001;
    cycle(g);
    req_valid = 3'b000;
    chk("tag0_cdb_valid", {63'd0, cdb_valid}, 64'd0);
    chk("tag0_err", {63'd0, err_tag0}, 64'd1);
    for (int k = 0; k < 3; k++) cycle(g);

    // Flush after grant to ALU
    do_reset();
    set_req(0, 1, 1, 32'hA0); set_req(1, 2, 2, 32'hA1); set_req(2, 3, 3, 32'hA2);
    req_valid = 3'b001;
    cycle(g);
    req_valid = 3'b111;
    flush = 1'b1;
    cycle(g);
    flush = 1'b0;
    chk("flush_cdb_valid", {63'd0, cdb_valid}, 64'd0);
    cycle(g);
    chk("post_flush_src", {62'd0, cdb_src}, 64'd0);
    req_valid = 3'b000;
    cycle(g);

    // Reset in the middle of a broadcast drops it
    set_req(2, 5, 3, 32'hBEEF);
    req_valid = 3'b100;
    cycle(g);
    rst = 1'b1;
    #1;
    chk("midrst_cdb_valid", {63'd0, cdb_valid}, 64'd0);
    chk("midrst_rf_we", {63'd0, rf_we}, 64'd0);
    chk("midrst_data", {32'd0, cdb_data}, 64'd0);
    chk("midrst_ready", {61'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 3'b000;
    model_reset();

    // Randomized traffic; requesters hold payload until accepted
    pend = 3'b000;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && ($urandom % 3 == 0)) begin
          set_req(i, ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 15)),
                  ($urandom % 6 == 0) ? 0 : int'($urandom_range(1, 31)), $urandom);
          pend[i] = 1'b1;
        end
      end
      req_valid = pend;
      flush = ($urandom % 16 == 0);
      cycle(g);
      if (g >= 0) pend[g] = 1'b0;
    end
    flush = 1'b0;
    req_valid = 3'b000;
    cycle(g);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
